// File: rtl/grid_uart_tx.sv
// Serialises a snapshot of the 8x8 life grid as an 8N1 UART frame: HEADER, then rows 0..7.
// Define GRID_TX_CHECKSUM_EN to append an XOR-of-rows checksum byte after row 7.
module grid_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] grid_flat,
    input  logic        start,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic        start_dropped
);

    typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
`ifdef GRID_TX_CHECKSUM_EN
    localparam logic [3:0]  LAST_BYTE = 4'd9;
`else
    localparam logic [3:0]  LAST_BYTE = 4'd8;
`endif

    state_t      state, state_nxt;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [63:0] snapshot;

    logic        bit_end;
    logic        last_byte;
    logic        accept;
    logic [2:0]  row_idx;
    logic [7:0]  row_byte;
    logic [7:0]  cur_byte;

    assign bit_end   = (baud_cnt == BAUD_MAX);
    assign last_byte = (byte_idx == LAST_BYTE);
    assign accept    = start && !busy;

    // Byte k (1..8) carries row k-1; the 3-bit wrap maps byte 8 onto row 7.
    assign row_idx  = byte_idx[2:0] - 3'd1;
    assign row_byte = snapshot[{row_idx, 3'b000} +: 8];

`ifdef GRID_TX_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int r = 0; r < 8; r++) begin
            checksum = checksum ^ snapshot[r*8 +: 8];
        end
    end

    always_comb begin
        if (byte_idx == 4'd0) begin
            cur_byte = HEADER;
        end else if (byte_idx == LAST_BYTE) begin
            cur_byte = checksum;
        end else begin
            cur_byte = row_byte;
        end
    end
`else
    always_comb begin
        if (byte_idx == 4'd0) begin
            cur_byte = HEADER;
        end else begin
            cur_byte = row_byte;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = START_BIT;
            START_BIT: if (bit_end) state_nxt = DATA;
            DATA:      if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP_BIT;
            STOP_BIT:  if (bit_end) state_nxt = last_byte ? IDLE : START_BIT;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            START_BIT: tx = 1'b0;
            DATA:      tx = cur_byte[bit_idx];
            default:   tx = 1'b1;
        endcase
    end

    // Counters, snapshot and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt      <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            snapshot      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            start_dropped <= 1'b0;
        end else begin
            frame_done    <= (state == STOP_BIT) && bit_end && last_byte;
            start_dropped <= start && busy;

            if (accept) begin
                snapshot <= grid_flat;
                byte_idx <= '0;
                bit_idx  <= '0;
                baud_cnt <= '0;
                busy     <= 1'b1;
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
                if (bit_end && (state == DATA)) begin
                    bit_idx <= bit_idx + 3'd1;
                end
                if (bit_end && (state == STOP_BIT)) begin
                    if (last_byte) begin
                        busy <= 1'b0;
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_uart_tx.sv
// Bench for grid_uart_tx: two instances (4 and 2 clocks per bit) checked against a frame model.
// Honours GRID_TX_CHECKSUM_EN for the expected frame length and checksum byte.
module tb_grid_uart_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 2;
`ifdef GRID_TX_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] grid_a, grid_b;
    logic        start_a, start_b;
    logic        tx_a, busy_a, fd_a, sd_a;
    logic        tx_b, busy_b, fd_b, sd_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grid_uart_tx #(.CLKS_PER_BIT(CPB_A), .HEADER(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .grid_flat(grid_a), .start(start_a),
        .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .start_dropped(sd_a)
    );

    grid_uart_tx #(.CLKS_PER_BIT(CPB_B), .HEADER(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .grid_flat(grid_b), .start(start_b),
        .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .start_dropped(sd_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: header, rows in order, optional XOR of the rows.
    function automatic logic [7:0] exp_byte(input logic [63:0] g, input int k);
        logic [7:0] x;
        x = 8'h00;
        if (k == 0) return 8'hA5;
        if (k <= 8) return 8'(g >> ((k - 1) * 8));
        for (int r = 0; r < 8; r++) x = x ^ 8'(g >> (r * 8));
        return x;
    endfunction

    function automatic logic tx_of(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic fd_of(input bit sel);
        return sel ? fd_b : fd_a;
    endfunction
    function automatic logic sd_of(input bit sel);
        return sel ? sd_b : sd_a;
    endfunction

    task automatic drive_start(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Pulses start; returns at the negedge right after the accepting edge.
    task automatic kick(input bit sel, input logic [63:0] g, input string tag);
        @(negedge clk);
        if (sel) grid_b = g;
        else     grid_a = g;
        drive_start(sel, 1'b1);
        @(negedge clk);
        drive_start(sel, 1'b0);
        chk({tag, "_txfall"}, 64'(tx_of(sel)), 64'd0);
        chk({tag, "_busy"}, 64'(busy_of(sel)), 64'd1);
    endtask

    // Records one frame starting at the tx fall and compares it with the model.
    task automatic capture(input bit sel, input string tag, input logic [63:0] g,
                           input int mut_byte, input int drops, input bit chain);
        int   cpb, total, early_fd, nd, terr, e;
        logic smp [0:399];
        logic [7:0] eb, db;
        cpb      = sel ? CPB_B : CPB_A;
        total    = NB * 10 * cpb;
        early_fd = 0;
        nd       = 0;
        terr     = 0;
        for (int t = 0; t < total; t++) begin
            if (t > 0) @(negedge clk);
            smp[t] = tx_of(sel);
            if (fd_of(sel)) early_fd++;
            if (sd_of(sel)) nd++;
            if (mut_byte > 0 && t == mut_byte * 10 * cpb) begin
                if (sel) grid_b = '1;
                else     grid_a = '1;
            end
            drive_start(sel, (drops > 0 && t > 0 && t % 20 == 0 && t / 20 <= drops));
        end
        @(negedge clk);
        drive_start(sel, 1'b0);
        if (sd_of(sel)) nd++;
        chk({tag, "_frame_done"}, 64'(fd_of(sel)), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy_of(sel)), 64'd0);
        chk({tag, "_early_done"}, 64'(early_fd), 64'd0);
        chk({tag, "_dropped"}, 64'(nd), 64'(drops));
        for (int k = 0; k < NB; k++) begin
            eb = exp_byte(g, k);
            db = 8'h00;
            for (int j = 0; j < 10; j++) begin
                e = (j == 0) ? 0 : (j == 9) ? 1 : int'(eb[j - 1]);
                for (int s = 0; s < cpb; s++)
                    if (smp[(k * 10 + j) * cpb + s] !== 1'(e)) terr++;
                if (j >= 1 && j <= 8) db[j - 1] = smp[(k * 10 + j) * cpb + cpb / 2];
            end
            chk($sformatf("%s_byte%0d", tag, k), 64'(db), 64'(eb));
        end
        chk({tag, "_bit_timing"}, 64'(terr), 64'd0);
        if (chain) begin
            drive_start(sel, 1'b1);
            @(negedge clk);
            drive_start(sel, 1'b0);
            chk({tag, "_b2b_txfall"}, 64'(tx_of(sel)), 64'd0);
            chk({tag, "_b2b_pulse"}, 64'(fd_of(sel)), 64'd0);
        end else begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(fd_of(sel)), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] g;
        int          fd_cnt;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        grid_a  = '0;
        grid_b  = '0;
        #1;
        chk("rst_tx", 64'(tx_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(fd_a), 64'd0);
        chk("rst_drop", 64'(sd_a), 64'd0);
        chk("rst_tx_b", 64'(tx_b), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        kick(0, 64'h0000_0000_0000_0001, "single");
        capture(0, "single", 64'h0000_0000_0000_0001, 0, 0, 0);

        kick(0, 64'h8040_2010_0804_0201, "diag");
        capture(0, "diag", 64'h8040_2010_0804_0201, 0, 0, 0);

        g = {$urandom, $urandom};
        kick(0, g, "iso");
        capture(0, "iso", g, 3, 0, 0);

        g = {$urandom, $urandom};
        kick(0, g, "drop");
        capture(0, "drop", g, 0, 3, 1);
        capture(0, "chain", g, 0, 0, 0);

        g = {$urandom, $urandom};
        kick(0, g, "abort");
        fd_cnt = 0;
        repeat ((5 * 10 + 3) * CPB_A) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_tx", 64'(tx_a), 64'd1);
        chk("abort_busy", 64'(busy_a), 64'd0);
        repeat (6) begin
            @(negedge clk);
            if (fd_a) fd_cnt++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (fd_a) fd_cnt++;
        end
        chk("abort_no_done", 64'(fd_cnt), 64'd0);
        g = {$urandom, $urandom};
        kick(0, g, "after_abort");
        capture(0, "after_abort", g, 0, 0, 0);

        kick(1, 64'hFFFF_FFFF_FFFF_FFFF, "ones_b");
        capture(1, "ones_b", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            g = {$urandom, $urandom};
            kick(1, g, "rand_b");
            capture(1, $sformatf("rand_b%0d", i), g, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
